// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed digit scanner.
//   scan_state_t : controller states (IDLE, BLANK, SHOW)
//   DEC_ON/OFF   : decoder enable codes (G1 high, G2A/G2B low = enabled)
//   NUM_DIGITS   : number of scanned digit positions
//   lowest_set   : index of the lowest set bit of a digit mask
//   nibble_at    : value nibble for a digit index out of the packed data word
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [2:0]  DEC_ON     = 3'b100;
  localparam logic [2:0]  DEC_OFF    = 3'b000;
  localparam int unsigned NUM_DIGITS = 8;

  // Returns 0 for an all-zero mask; callers only use it on non-zero masks.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (m[7 - i]) r = 3'(7 - i);
    end
    return r;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [31:0] d, input logic [2:0] i);
    return d[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/next_digit_sel.sv
// Circular next-set-bit search over an 8-digit mask.
//   mask : digits taking part in the scan
//   cur  : digit currently shown
//   nxt  : first set mask bit strictly above cur, searching circularly
//          (returns cur itself when it is the only set bit, cur when mask=0)
//   wrap : the search passed digit 7 -> 0 or landed back on cur (nxt <= cur)
import scan_pkg::*;

module next_digit_sel (
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  output logic [2:0] nxt,
  output logic       wrap
);

  logic       found;
  logic [2:0] cand;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = cur;
    // k = NUM_DIGITS lands back on cur, which covers the single-digit mask.
    for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
      cand = cur + 3'(k);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 8-digit display scanner driving a 3-to-8 active-low
// decoder. Each scanned digit gets BLANK_CYCLES clocks with the decoder
// disabled (anti-ghosting) followed by DWELL_CYCLES clocks enabled.
// Mask and data are shadowed and only re-sampled at frame start or wrap.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   run         : scanning enable
//   digit_mask  : bit i set = digit i is scanned
//   digit_data  : nibble i = value for digit i
//   dec_sel     : decoder select (digit index)
//   dec_en      : decoder enables, 3'b100 on / 3'b000 off
//   digit_val   : shadowed nibble for the digit on dec_sel
//   frame_tick  : one-clock pulse per completed frame
import scan_pkg::*;

module digit_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  digit_mask,
  input  logic [31:0] digit_data,
  output logic [2:0]  dec_sel,
  output logic [2:0]  dec_en,
  output logic [3:0]  digit_val,
  output logic        frame_tick
);

  // Sized by the dwell length; also covers the blank length when a very
  // short dwell is paired with a longer blank.
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Counter holds "clocks remaining minus one"; the phase ends when it is 0,
  // so it never decrements past zero.
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  scan_state_t       state;
  logic [2:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        sh_mask;
  logic [31:0]       sh_data;

  logic [2:0]        adv_idx;
  logic              adv_wrap;
  logic [2:0]        first_idx;

  next_digit_sel u_next (
    .mask (sh_mask),
    .cur  (idx),
    .nxt  (adv_idx),
    .wrap (adv_wrap)
  );

  assign first_idx = lowest_set(digit_mask);

  // Outputs are written alongside the state so they always describe the
  // state being entered; dec_sel only ever moves while entering BLANK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      sh_mask    <= '0;
      sh_data    <= '0;
      dec_sel    <= '0;
      dec_en     <= DEC_OFF;
      digit_val  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          dec_en    <= DEC_OFF;
          digit_val <= '0;
          cnt       <= '0;
          if (run && (digit_mask != '0)) begin
            sh_mask   <= digit_mask;
            sh_data   <= digit_data;
            idx       <= first_idx;
            dec_sel   <= first_idx;
            digit_val <= nibble_at(digit_data, first_idx);
            cnt       <= BLANK_LOAD;
            state     <= BLANK;
          end
        end

        BLANK: begin
          if (!run) begin
            state     <= IDLE;
            dec_en    <= DEC_OFF;
            digit_val <= '0;
            cnt       <= '0;
          end else if (cnt == '0) begin
            state  <= SHOW;
            dec_en <= DEC_ON;
            cnt    <= DWELL_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SHOW: begin
          if (!run) begin
            state     <= IDLE;
            dec_en    <= DEC_OFF;
            digit_val <= '0;
            cnt       <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            dec_en <= DEC_OFF;
            cnt    <= BLANK_LOAD;
            if (!adv_wrap) begin
              idx       <= adv_idx;
              dec_sel   <= adv_idx;
              digit_val <= nibble_at(sh_data, adv_idx);
              state     <= BLANK;
            end else begin
              // Frame boundary: new mask/data take effect here only.
              frame_tick <= 1'b1;
              sh_mask    <= digit_mask;
              sh_data    <= digit_data;
              if (digit_mask != '0) begin
                idx       <= first_idx;
                dec_sel   <= first_idx;
                digit_val <= nibble_at(digit_data, first_idx);
                state     <= BLANK;
              end else begin
                digit_val <= '0;
                cnt       <= '0;
                state     <= IDLE;
              end
            end
          end
        end

        default: begin
          state     <= IDLE;
          dec_en    <= DEC_OFF;
          digit_val <= '0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
module tb_digit_scan_ctrl;

  localparam int D = 4;
  localparam int B = 2;
  localparam int P = B + D;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  mask;
  logic [31:0] data;
  logic [2:0]  dec_sel;
  logic [2:0]  dec_en;
  logic [3:0]  digit_val;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;

  digit_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .digit_mask (mask),
    .digit_data (data),
    .dec_sel    (dec_sel),
    .dec_en     (dec_en),
    .digit_val  (digit_val),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A frame is a list of scanned digits; position t in the frame maps to
  // digit list[t / P], decoder off for the first B clocks of each slot.
  bit          m_active;
  int          m_t;
  int          m_list[$];
  logic [31:0] m_data;
  logic [2:0]  m_sel;
  logic        m_tick;

  task automatic model_reset();
    m_active = 0; m_t = 0; m_list.delete(); m_data = '0; m_sel = '0; m_tick = 0;
  endtask

  task automatic model_latch(input logic [7:0] mk, input logic [31:0] dt);
    m_data = dt;
    m_list.delete();
    for (int i = 0; i < 8; i++) if (mk[i]) m_list.push_back(i);
  endtask

  task automatic model_step(input logic r, input logic [7:0] mk, input logic [31:0] dt);
    m_tick = 0;
    if (!m_active) begin
      if (r && mk != 0) begin
        model_latch(mk, dt); m_t = 0; m_active = 1;
      end
    end else if (!r) begin
      m_active = 0;
    end else begin
      m_t++;
      if (m_t == m_list.size() * P) begin
        m_tick = 1;
        model_latch(mk, dt);
        if (mk != 0) m_t = 0;
        else m_active = 0;
      end
    end
    if (m_active) m_sel = 3'(m_list[m_t / P]);
  endtask

  function automatic logic [10:0] model_out();
    logic [2:0] en;
    logic [3:0] v;
    en = (m_active && (m_t % P) >= B) ? 3'b100 : 3'b000;
    v  = m_active ? m_data[4*m_sel +: 4] : 4'h0;
    return {m_sel, en, v, m_tick};
  endfunction

  // One clock: model follows the inputs seen at the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(run, mask, data);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mask = '0; data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", {dec_sel, dec_en, digit_val, frame_tick}, 11'h0);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- table-driven patterns ----------------
  typedef struct {
    logic [7:0]  mask;
    logic [31:0] data;
    int          period;
    int          n;
    logic [23:0] seq;   // seq[3k+:3] = k-th digit shown
  } vec_t;

  vec_t tbl[3];

  task automatic run_pattern(input vec_t v);
    int          ticks[$];
    logic [2:0]  shows[$];
    logic [2:0]  prev_en;
    int          run_len, bad_len, bad_val, ncyc, tick_sel_bad;
    logic [2:0]  s0;
    do_reset();
    mask = v.mask; data = v.data; run = 1'b1;
    prev_en = 3'b000; run_len = 0; bad_len = 0; bad_val = 0; tick_sel_bad = 0;
    s0 = v.seq[2:0];
    ncyc = 2 * v.period + 2 * P + 2;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (frame_tick) begin
        ticks.push_back(c);
        if (dec_sel !== s0 || dec_en !== 3'b000) tick_sel_bad++;
      end
      if (dec_en !== prev_en) begin
        if (prev_en == 3'b000 && run_len != B) bad_len++;
        if (prev_en == 3'b100 && run_len != D) bad_len++;
        if (dec_en == 3'b100) shows.push_back(dec_sel);
        run_len = 1;
      end else begin
        run_len++;
      end
      if (dec_en == 3'b100 && digit_val !== v.data[4*dec_sel +: 4]) bad_val++;
      prev_en = dec_en;
    end
    check("pattern tick count>=2", 64'(ticks.size() >= 2), 64'd1);
    if (ticks.size() >= 2) begin
      check("pattern first tick", 64'(ticks[0]), 64'(v.period));
      check("pattern frame period", 64'(ticks[1] - ticks[0]), 64'(v.period));
    end
    check("pattern en run lengths", 64'(bad_len), 64'd0);
    check("pattern digit_val", 64'(bad_val), 64'd0);
    check("pattern tick on wrap", 64'(tick_sel_bad), 64'd0);
    check("pattern shows >= n+1", 64'(shows.size() >= v.n + 1), 64'd1);
    if (shows.size() >= v.n + 1) begin
      for (int k = 0; k < v.n; k++)
        check($sformatf("pattern seq[%0d]", k), 64'(shows[k]), 64'(v.seq[3*k +: 3]));
      check("pattern seq wrap", 64'(shows[v.n]), 64'(s0));
    end
  endtask

  initial begin
    int bad, found;

    tbl[0] = '{mask: 8'hFF,        data: 32'h76543210, period: 48, n: 8,
               seq: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[1] = '{mask: 8'b1000_0101, data: 32'h9ABCDEF1, period: 18, n: 3,
               seq: {15'd0, 3'd7, 3'd2, 3'd0}};
    tbl[2] = '{mask: 8'h10,        data: 32'h000C0000, period: 6,  n: 1,
               seq: {21'd0, 3'd4}};

    for (int i = 0; i < 3; i++) run_pattern(tbl[i]);

    // Data changed mid-frame only shows after the wrap.
    do_reset();
    mask = 8'h03; data = 32'h0; run = 1'b1;
    for (int c = 0; c < 3; c++) step();
    data = 32'hFFFF_FFFF;
    bad = 0; found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      step();
      if (frame_tick) found = 1;
      else if (digit_val !== 4'h0) bad++;
    end
    check("midframe data tick seen", 64'(found), 64'd1);
    check("midframe data held", 64'(bad), 64'd0);
    check("midframe data after wrap", 64'(digit_val), 64'hF);

    // run dropped during SHOW of digit 3.
    do_reset();
    mask = 8'hFF; data = 32'h76543210; run = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (dec_sel == 3'd3 && dec_en == 3'b100) found = 1;
    end
    check("reach SHOW digit 3", 64'(found), 64'd1);
    run = 1'b0;
    step();
    check("run drop en/val/tick", {dec_en, digit_val, frame_tick}, 8'h0);
    mask = 8'h00; run = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if ({dec_en, digit_val, frame_tick} !== 8'h0) bad++;
    end
    check("mask zero stays idle", 64'(bad), 64'd0);

    // Asynchronous reset in the middle of SHOW.
    do_reset();
    mask = 8'hFF; data = 32'h76543210; run = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (dec_en == 3'b100) found = 1;
    end
    check("reach SHOW for reset", 64'(found), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset dec_en", 64'(dec_en), 64'd0);
    check("async reset outputs", {dec_sel, dec_en, digit_val, frame_tick}, 11'h0);

    // Randomised traffic against the reference model.
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) begin
        if ($urandom_range(0, 9) == 0) mask = 8'h00;
        else if ($urandom_range(0, 3) == 0) mask = 8'(1 << $urandom_range(0, 7));
        else mask = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 4) data = $urandom;
      if (run) begin
        if ($urandom_range(0, 299) == 0) run = 1'b0;
      end else if ($urandom_range(0, 4) == 0) run = 1'b1;
      step();
      check("random vs model", {dec_sel, dec_en, digit_val, frame_tick}, model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
